// File: rtl/operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : operand_sequencer
// Purpose : Key-entry FSM that assembles operand1/operator/operand2 from
//           eBCD key events, waits for the calculator result and drives the
//           display word.
// Revision: 1.0 - initial release
// ============================================================================
module operand_sequencer #(
    parameter int         MAX_DIGITS = 6,
    parameter int         CALC_LAT   = 1,
    parameter logic [4:0] KEY_IDLE   = 5'h1F
) (
    input  logic        sw_clk,
    input  logic        rst,
    input  logic [4:0]  eBCD,
    input  logic [31:0] ans,
    output logic [31:0] operand1,
    output logic [31:0] operand2,
    output logic [2:0]  operator,
    output logic        busy,
    output logic [31:0] fnd_serial
);

    localparam int          c_CNT_W     = $clog2(CALC_LAT + 1);
    localparam int          c_DIG_W     = $clog2(MAX_DIGITS + 1);
    localparam logic [4:0]  c_KEY_SUB   = 5'h0B;
    localparam logic [4:0]  c_KEY_EQ    = 5'h0F;
    localparam logic [4:0]  c_KEY_CLR   = 5'h10;
    localparam logic [31:0] c_ERR_WORD  = 32'h00EE_0000;
    localparam logic [31:0] c_HAPPY     = 32'h00A0_0000;
    localparam logic [c_DIG_W-1:0] c_LIM_POS  = c_DIG_W'(MAX_DIGITS);
    localparam logic [c_DIG_W-1:0] c_LIM_NEG  = c_DIG_W'(MAX_DIGITS - 1);
    localparam logic [c_CNT_W-1:0] c_LAT_INIT = c_CNT_W'(CALC_LAT);

    typedef enum logic [2:0] {
        S_START    = 3'd0,
        S_ENTER_A  = 3'd1,
        S_OP_SHOWN = 3'd2,
        S_ENTER_B  = 3'd3,
        S_WAIT     = 3'd4,
        S_RESULT   = 3'd5,
        S_ERROR    = 3'd6
    } state_t;

    state_t               r_state,    w_state_nxt;
    logic [4:0]           r_prev_key;
    logic [31:0]          r_op1,      w_op1_nxt;
    logic [31:0]          r_op2,      w_op2_nxt;
    logic [31:0]          r_mag1,     w_mag1_nxt;
    logic [31:0]          r_mag2,     w_mag2_nxt;
    logic [c_DIG_W-1:0]   r_cnt1,     w_cnt1_nxt;
    logic [c_DIG_W-1:0]   r_cnt2,     w_cnt2_nxt;
    logic                 r_neg1,     w_neg1_nxt;
    logic                 r_neg2,     w_neg2_nxt;
    logic [2:0]           r_oper,     w_oper_nxt;
    logic                 r_busy,     w_busy_nxt;
    logic [c_CNT_W-1:0]   r_lat_cnt,  w_lat_cnt_nxt;
    logic                 r_clr_pend, w_clr_pend_nxt;
    logic [31:0]          r_ans,      w_ans_nxt;
    logic [31:0]          r_fnd,      w_fnd_nxt;

    logic                 w_event;
    logic                 w_is_digit;
    logic                 w_is_op;
    logic [2:0]           w_op_code;
    logic [31:0]          w_digit;
    logic [31:0]          w_app1;
    logic [31:0]          w_app2;
    logic [c_DIG_W-1:0]   w_lim1;
    logic [c_DIG_W-1:0]   w_lim2;
    logic [3:0]           w_glyph;
    logic                 w_do_clear;

    function automatic logic [31:0] f_signed(input logic neg, input logic [31:0] mag);
        return neg ? (~mag + 32'd1) : mag;
    endfunction

    // A press is the first non-idle code after an idle sample.
    assign w_event    = (eBCD != KEY_IDLE) && (r_prev_key == KEY_IDLE);
    assign w_is_digit = (eBCD <= 5'd9);
    assign w_is_op    = (eBCD >= 5'h0A) && (eBCD <= 5'h0E);
    assign w_op_code  = eBCD[2:0] - 3'd2;
    assign w_digit    = {28'd0, eBCD[3:0]};
    assign w_app1     = (r_mag1 * 32'd10) + w_digit;
    assign w_app2     = (r_mag2 * 32'd10) + w_digit;
    assign w_lim1     = r_neg1 ? c_LIM_NEG : c_LIM_POS;
    assign w_lim2     = r_neg2 ? c_LIM_NEG : c_LIM_POS;

    always_comb begin
        w_state_nxt    = r_state;
        w_op1_nxt      = r_op1;
        w_op2_nxt      = r_op2;
        w_mag1_nxt     = r_mag1;
        w_mag2_nxt     = r_mag2;
        w_cnt1_nxt     = r_cnt1;
        w_cnt2_nxt     = r_cnt2;
        w_neg1_nxt     = r_neg1;
        w_neg2_nxt     = r_neg2;
        w_oper_nxt     = r_oper;
        w_busy_nxt     = r_busy;
        w_lat_cnt_nxt  = r_lat_cnt;
        w_clr_pend_nxt = r_clr_pend;
        w_ans_nxt      = r_ans;
        w_fnd_nxt      = r_fnd;
        w_glyph        = 4'd0;
        w_do_clear     = 1'b0;

        if (r_state == S_WAIT) begin
            if (w_event && (eBCD == c_KEY_CLR)) begin
                w_clr_pend_nxt = 1'b1;
            end
            if (r_lat_cnt > c_CNT_W'(1)) begin
                w_lat_cnt_nxt = r_lat_cnt - c_CNT_W'(1);
            end else begin
                w_busy_nxt     = 1'b0;
                w_lat_cnt_nxt  = '0;
                w_clr_pend_nxt = 1'b0;
                w_neg1_nxt     = 1'b0;
                if (r_clr_pend || (w_event && (eBCD == c_KEY_CLR))) begin
                    w_do_clear = 1'b1;
                end else if (ans == c_ERR_WORD) begin
                    w_state_nxt = S_ERROR;
                end else begin
                    w_state_nxt = S_RESULT;
                    w_ans_nxt   = ans;
                end
            end
        end else if (w_event) begin
            if (eBCD == c_KEY_CLR) begin
                w_do_clear = 1'b1;
            end else if (w_is_digit) begin
                case (r_state)
                    S_START, S_RESULT, S_ERROR: begin
                        w_mag1_nxt  = w_digit;
                        w_cnt1_nxt  = c_DIG_W'(1);
                        w_op1_nxt   = f_signed(r_neg1, w_digit);
                        w_state_nxt = S_ENTER_A;
                    end
                    S_ENTER_A: begin
                        if (r_cnt1 < w_lim1) begin
                            w_mag1_nxt = w_app1;
                            w_cnt1_nxt = r_cnt1 + c_DIG_W'(1);
                            w_op1_nxt  = f_signed(r_neg1, w_app1);
                        end
                    end
                    S_OP_SHOWN: begin
                        w_mag2_nxt  = w_digit;
                        w_cnt2_nxt  = c_DIG_W'(1);
                        w_op2_nxt   = f_signed(r_neg2, w_digit);
                        w_state_nxt = S_ENTER_B;
                    end
                    S_ENTER_B: begin
                        if (r_cnt2 < w_lim2) begin
                            w_mag2_nxt = w_app2;
                            w_cnt2_nxt = r_cnt2 + c_DIG_W'(1);
                            w_op2_nxt  = f_signed(r_neg2, w_app2);
                        end
                    end
                    default: ;
                endcase
            end else if ((eBCD == c_KEY_SUB) &&
                         ((r_state == S_START) || (r_state == S_RESULT) || (r_state == S_ERROR))) begin
                w_neg1_nxt = 1'b1;
            end else if ((eBCD == c_KEY_SUB) && (r_state == S_OP_SHOWN)) begin
                w_neg2_nxt = 1'b1;
            end else if (w_is_op) begin
                case (r_state)
                    S_ENTER_A, S_RESULT: begin
                        // Chaining: a finished result becomes the new first operand.
                        if (r_state == S_RESULT) begin
                            w_op1_nxt = r_ans;
                        end
                        w_oper_nxt  = w_op_code;
                        w_op2_nxt   = '0;
                        w_mag2_nxt  = '0;
                        w_cnt2_nxt  = '0;
                        w_neg2_nxt  = 1'b0;
                        w_neg1_nxt  = 1'b0;
                        w_state_nxt = S_OP_SHOWN;
                    end
                    S_OP_SHOWN: w_oper_nxt = w_op_code;
                    default: ;
                endcase
            end else if ((eBCD == c_KEY_EQ) && (r_state == S_ENTER_B)) begin
                w_busy_nxt    = 1'b1;
                w_lat_cnt_nxt = c_LAT_INIT;
                w_state_nxt   = S_WAIT;
            end
        end

        if (w_do_clear) begin
            w_op1_nxt   = '0;
            w_op2_nxt   = '0;
            w_mag1_nxt  = '0;
            w_mag2_nxt  = '0;
            w_cnt1_nxt  = '0;
            w_cnt2_nxt  = '0;
            w_neg1_nxt  = 1'b0;
            w_neg2_nxt  = 1'b0;
            w_oper_nxt  = 3'd0;
            w_state_nxt = S_ENTER_A;
        end

        w_glyph = {1'b0, w_oper_nxt} + 4'd1;
        case (w_state_nxt)
            S_START:             w_fnd_nxt = c_HAPPY;
            S_ENTER_A:           w_fnd_nxt = w_op1_nxt;
            S_OP_SHOWN:          w_fnd_nxt = {8'h00, w_glyph, 20'h00000};
            S_ENTER_B, S_WAIT:   w_fnd_nxt = w_op2_nxt;
            S_RESULT:            w_fnd_nxt = w_ans_nxt;
            default:             w_fnd_nxt = c_ERR_WORD;
        endcase
    end

    always_ff @(posedge sw_clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_START;
            r_prev_key <= KEY_IDLE;
            r_op1      <= '0;
            r_op2      <= '0;
            r_mag1     <= '0;
            r_mag2     <= '0;
            r_cnt1     <= '0;
            r_cnt2     <= '0;
            r_neg1     <= 1'b0;
            r_neg2     <= 1'b0;
            r_oper     <= 3'd0;
            r_busy     <= 1'b0;
            r_lat_cnt  <= '0;
            r_clr_pend <= 1'b0;
            r_ans      <= '0;
            r_fnd      <= c_HAPPY;
        end else begin
            r_state    <= w_state_nxt;
            r_prev_key <= eBCD;
            r_op1      <= w_op1_nxt;
            r_op2      <= w_op2_nxt;
            r_mag1     <= w_mag1_nxt;
            r_mag2     <= w_mag2_nxt;
            r_cnt1     <= w_cnt1_nxt;
            r_cnt2     <= w_cnt2_nxt;
            r_neg1     <= w_neg1_nxt;
            r_neg2     <= w_neg2_nxt;
            r_oper     <= w_oper_nxt;
            r_busy     <= w_busy_nxt;
            r_lat_cnt  <= w_lat_cnt_nxt;
            r_clr_pend <= w_clr_pend_nxt;
            r_ans      <= w_ans_nxt;
            r_fnd      <= w_fnd_nxt;
        end
    end

    assign operand1   = r_op1;
    assign operand2   = r_op2;
    assign operator   = r_oper;
    assign busy       = r_busy;
    assign fnd_serial = r_fnd;

endmodule
`default_nettype wire

// File: tb/tb_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_operand_sequencer
// Purpose : Directed + randomized key sequences against a key-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_operand_sequencer;

    localparam int          MAXD  = 6;
    localparam int          LAT   = 3;
    localparam logic [4:0]  IDLE  = 5'h1F;
    localparam logic [31:0] ERRW  = 32'h00EE_0000;
    localparam logic [31:0] HAPPY = 32'h00A0_0000;

    localparam int M_START = 0, M_A = 1, M_OP = 2, M_B = 3, M_WAIT = 4, M_RES = 5, M_ERR = 6;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  key   = IDLE;
    logic [31:0] ans   = 32'd0;
    logic [31:0] op1, op2, fnd;
    logic [2:0]  opr;
    logic        busy;
    bit          chk_en = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    operand_sequencer #(.MAX_DIGITS(MAXD), .CALC_LAT(LAT), .KEY_IDLE(IDLE)) dut (
        .sw_clk    (clk),
        .rst       (rst_n),
        .eBCD      (key),
        .ans       (ans),
        .operand1  (op1),
        .operand2  (op2),
        .operator  (opr),
        .busy      (busy),
        .fnd_serial(fnd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- key-level reference model ----------------
    int          md, a_mag, b_mag, a_cnt, b_cnt, m_opr, wait_left;
    bit          a_neg, b_neg, clr_later, m_busy;
    logic [31:0] m_op1, m_op2, m_res;
    logic [4:0]  m_prev;

    task automatic m_reset();
        md = M_START; a_mag = 0; b_mag = 0; a_cnt = 0; b_cnt = 0; m_opr = 0;
        wait_left = 0; a_neg = 0; b_neg = 0; clr_later = 0; m_busy = 0;
        m_op1 = 0; m_op2 = 0; m_res = 0; m_prev = IDLE;
    endtask

    task automatic m_clear();
        md = M_A; m_op1 = 0; m_op2 = 0; m_opr = 0;
        a_neg = 0; b_neg = 0; a_mag = 0; b_mag = 0; a_cnt = 0; b_cnt = 0;
    endtask

    task automatic m_digit_a(input int d, input bit fresh);
        if (fresh) begin a_mag = 0; a_cnt = 0; end
        if (a_cnt < (a_neg ? MAXD - 1 : MAXD)) begin
            a_mag = a_mag * 10 + d; a_cnt++;
            m_op1 = a_neg ? -a_mag : a_mag;
        end
        md = M_A;
    endtask

    task automatic m_digit_b(input int d, input bit fresh);
        if (fresh) begin b_mag = 0; b_cnt = 0; end
        if (b_cnt < (b_neg ? MAXD - 1 : MAXD)) begin
            b_mag = b_mag * 10 + d; b_cnt++;
            m_op2 = b_neg ? -b_mag : b_mag;
        end
        md = M_B;
    endtask

    task automatic m_step();
        bit ev;
        int kv;
        ev = (key != IDLE) && (m_prev == IDLE);
        m_prev = key;
        kv = int'(key);
        if (md == M_WAIT) begin
            if (ev && kv == 16) clr_later = 1;
            wait_left--;
            if (wait_left == 0) begin
                m_busy = 0; a_neg = 0;
                if (clr_later) m_clear();
                else if (ans == ERRW) md = M_ERR;
                else begin md = M_RES; m_res = ans; end
                clr_later = 0;
            end
        end else if (ev) begin
            if (kv == 16) m_clear();
            else if (kv <= 9) begin
                if (md == M_START || md == M_RES || md == M_ERR) m_digit_a(kv, 1);
                else if (md == M_A)  m_digit_a(kv, 0);
                else if (md == M_OP) m_digit_b(kv, 1);
                else if (md == M_B)  m_digit_b(kv, 0);
            end else if (kv == 11 && (md == M_START || md == M_RES || md == M_ERR)) a_neg = 1;
            else if (kv == 11 && md == M_OP) b_neg = 1;
            else if (kv >= 10 && kv <= 14) begin
                if (md == M_A || md == M_RES) begin
                    if (md == M_RES) m_op1 = m_res;
                    m_opr = kv - 10; m_op2 = 0; b_mag = 0; b_cnt = 0; b_neg = 0; md = M_OP;
                end else if (md == M_OP) m_opr = kv - 10;
            end else if (kv == 15 && md == M_B) begin
                md = M_WAIT; wait_left = LAT; m_busy = 1;
            end
        end
    endtask

    function automatic logic [31:0] m_disp();
        case (md)
            M_START:      return HAPPY;
            M_A:          return m_op1;
            M_OP:         return 32'((m_opr + 1) << 20);
            M_B, M_WAIT:  return m_op2;
            M_RES:        return m_res;
            default:      return ERRW;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_reset();
        else        m_step();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("operand1", op1, m_op1);
            check("operand2", op2, m_op2);
            check("operator", {29'd0, opr}, 32'(m_opr));
            check("busy", {31'd0, busy}, {31'd0, m_busy});
            check("fnd_serial", fnd, m_disp());
        end
    end

    // ---------------- stimulus helpers (entered/left at posedge+1) ----------------
    task automatic press_n(input logic [4:0] k, input int hold);
        key = k;
        repeat (hold) @(posedge clk);
        #1 key = IDLE;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] k);
        press_n(k, 2);
    endtask

    task automatic pulse_reset();
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hi;
        int r;
        logic [4:0] k;

        #12 rst_n = 1'b1;
        @(posedge clk);
        #1 chk_en = 1'b1;

        check("reset_fnd", fnd, HAPPY);
        check("reset_op1", op1, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);

        press(5'd1); check("fnd_1", fnd, 32'd1);
        press(5'd2); check("fnd_12", fnd, 32'd12);
        press(5'd3); check("op1_123", op1, 32'd123);
        check("fnd_123", fnd, 32'd123);

        press(5'h10); check("clear_fnd", fnd, 32'd0);
        press(5'd1); press(5'd0); press(5'h0A);
        check("glyph_plus", fnd, 32'h0010_0000);
        press(5'd1); press(5'd0); press(5'd1);
        ans = 32'd111;
        key = 5'h0F;
        @(posedge clk);
        #1 key = IDLE;
        hi = 0;
        for (int c = 0; c < 20; c++) begin
            if (!busy) break;
            hi++;
            @(posedge clk);
            #1;
        end
        check("busy_cycles", 32'(hi), 32'(LAT));
        check("result_111", fnd, 32'd111);
        check("op2_101", op2, 32'd101);
        check("oper_add", {29'd0, opr}, 32'd0);

        ans = 32'd222;
        press(5'h0C);
        check("chain_op1", op1, 32'd111);
        check("glyph_mul", fnd, 32'h0030_0000);
        press(5'd2); press(5'h0F);
        check("result_222", fnd, 32'd222);

        press(5'h0B); press(5'd1); press(5'd0);
        check("op1_neg10", op1, 32'hFFFF_FFF6);
        press(5'h0B);
        check("glyph_sub", fnd, 32'h0020_0000);
        check("oper_sub", {29'd0, opr}, 32'd1);
        ans = 32'hFFFF_FFA5;
        press(5'd1); press(5'd0); press(5'd1); press(5'h0F);
        check("op2_101b", op2, 32'd101);

        for (int i = 0; i < 7; i++) press(5'd9);
        check("op1_999999", op1, 32'd999999);
        pulse_reset();
        press(5'h0B);
        for (int i = 0; i < 6; i++) press(5'd9);
        check("op1_neg99999", op1, 32'hFFFE_7961);

        pulse_reset();
        key = 5'd5;
        repeat (20) @(posedge clk);
        #1 key = 5'd6;
        repeat (5) @(posedge clk);
        #1 key = IDLE;
        repeat (2) @(posedge clk);
        #1 check("hold_5", op1, 32'd5);

        press(5'h10); press(5'd1); press(5'h0D); press(5'd0);
        ans = ERRW;
        press(5'h0F);
        check("err_fnd", fnd, ERRW);
        press(5'h0A);
        check("err_op_ignored", fnd, ERRW);
        check("err_oper_kept", {29'd0, opr}, 32'd3);
        press(5'h10);
        check("err_clear_fnd", fnd, 32'd0);

        press(5'd4); press(5'h0A); press(5'd4);
        ans = 32'd8;
        key = 5'h0F;
        @(posedge clk); #1 key = IDLE;
        @(posedge clk); #1 key = 5'h10;
        @(posedge clk); #1 key = IDLE;
        @(posedge clk); #1;
        check("defer_clr_fnd", fnd, 32'd0);
        check("defer_clr_op2", op2, 32'd0);
        check("defer_clr_busy", {31'd0, busy}, 32'd0);

        press(5'd7); press(5'h0C); press(5'd3);
        ans = 32'd21;
        key = 5'h0F;
        @(posedge clk);
        #1 key = IDLE;
        check("wait_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check("rst_wait_busy", {31'd0, busy}, 32'd0);
        check("rst_wait_fnd", fnd, HAPPY);
        check("rst_wait_op1", op1, 32'd0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 99);
            if      (r < 50) k = 5'($urandom_range(0, 9));
            else if (r < 72) k = 5'($urandom_range(10, 14));
            else if (r < 84) k = 5'h0F;
            else if (r < 89) k = 5'h10;
            else             k = 5'($urandom_range(17, 30));
            if (md != M_WAIT) ans = ($urandom_range(0, 5) == 0) ? ERRW : $urandom;
            r = $urandom_range(0, 19);
            if (r < 3) begin
                press_n(k, $urandom_range(3, 10));
            end else if (r < 5) begin
                key = k;
                @(posedge clk);
                #1 key = 5'($urandom_range(0, 16));
                @(posedge clk);
                #1 key = IDLE;
                repeat (2) @(posedge clk);
                #1;
            end else if (r < 8) begin
                key = k;
                @(posedge clk);
                #1 key = IDLE;
                @(posedge clk);
                #1;
            end else if (r == 8 && $urandom_range(0, 3) == 0) begin
                pulse_reset();
            end else begin
                press(k);
            end
        end

        repeat (LAT + 2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
